branch_predictor: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters. It supplies the `predict` bit and predicted target to the fetch stage, and it is trained by the resolved branch outcome from EX. It also owns a soft-clear sweep state machine and branch and mispredict statistics counters. It sits between IF, which performs the lookup, and EX, which performs the update and raises the mispredict.

---
 rtl/branch_predictor_pkg.sv | 19 +
 rtl/branch_predictor_sat_counter2.sv | 20 ++
 rtl/branch_predictor.sv | 188 ++++++++++++++++++
 tb/tb_branch_predictor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch target buffer: word width,
// 2-bit direction counter encodings and the soft-clear sweep states.
package branch_predictor_pkg;

    localparam int unsigned WORD = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } sweep_state_e;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (inc_i && !dec_i && (cnt_i != ST)) begin
            cnt_o = cnt_i + 2'd1;
        end else if (dec_i && !inc_i && (cnt_i != SNT)) begin
            cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, soft-clear sweep FSM
// and branch/mispredict statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        ex_mispredict,
    input  logic        clear_req,
    output logic        busy,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int unsigned TAG_W = WORD - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         cnt_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [WORD-1:0]    tgt_q [ENTRIES];

    sweep_state_e       state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               sweep_start;
    logic               sweep_clr;

    logic [31:0]        br_cnt_q, br_cnt_d;
    logic [31:0]        mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0]   if_idx, ex_idx;
    logic [TAG_W-1:0]   if_tag, ex_tag;
    logic               if_hit, ex_hit;
    logic               upd_en, alloc, train;
    logic [1:0]         ex_cnt_next;

    logic               unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    // Lookup path (IF)
    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[WORD-1:IDX_W+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    always_comb begin
        if_pred_taken  = if_hit && cnt_q[if_idx][1] && !busy;
        if_pred_target = if_pred_taken ? tgt_q[if_idx] : (if_pc + 32'd4);
    end

    // Resolution path (EX); mispredict is independent of the sweep
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[WORD-1:IDX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_comb begin
        ex_mispredict = ex_is_branch &&
                        ((ex_taken ^ ex_pred_taken) ||
                         (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
    end

    // A concurrent clear request wins over the update
    assign upd_en = ex_is_branch && !busy && !clear_req;
    assign alloc  = upd_en && !ex_hit && ex_taken;
    assign train  = upd_en && ex_hit;

    sat_counter2 u_sat_counter2 (
        .cnt_i (cnt_q[ex_idx]),
        .inc_i (ex_taken),
        .dec_i (!ex_taken),
        .cnt_o (ex_cnt_next)
    );

    // Valid bits and counters carry reset; sweep and update never overlap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= WNT;
            end
        end else begin
            if (sweep_clr) begin
                valid_q[ptr_q] <= 1'b0;
            end
            if (alloc) begin
                valid_q[ex_idx] <= 1'b1;
                cnt_q[ex_idx]   <= WT;
            end else if (train) begin
                cnt_q[ex_idx] <= ex_cnt_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            tag_q[ex_idx] <= ex_tag;
            tgt_q[ex_idx] <= ex_target;
        end else if (train && ex_taken) begin
            tgt_q[ex_idx] <= ex_target;
        end
    end

    // Sweep FSM: state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Sweep FSM: next state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d = S_SWEEP;
                    ptr_d   = '0;
                end
            end
            S_SWEEP: begin
                ptr_d = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sweep FSM: outputs
    always_comb begin
        busy        = 1'b0;
        sweep_clr   = 1'b0;
        sweep_start = 1'b0;
        unique case (state_q)
            S_IDLE:  sweep_start = clear_req;
            S_SWEEP: begin
                busy      = 1'b1;
                sweep_clr = 1'b1;
            end
            default: ;
        endcase
    end

    // Statistics
    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (sweep_start) begin
            br_cnt_d  = '0;
            mis_cnt_d = '0;
        end else if (upd_en) begin
            br_cnt_d = br_cnt_q + 32'd1;
            if (ex_mispredict) begin
                mis_cnt_d = mis_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign stat_branches    = br_cnt_q;
    assign stat_mispredicts = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor at the default 16 entries.
module tb_branch_predictor;

    logic        clk;
    logic        rstn;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_mispredict;
    logic        clear_req;
    logic        busy;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int n_vec;
    int n_err;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .if_pred_target   (if_pred_target),
        .ex_is_branch     (ex_is_branch),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .ex_mispredict    (ex_mispredict),
        .clear_req        (clear_req),
        .busy             (busy),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_ex(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                            input logic ptk, input logic [31:0] ptg);
        ex_is_branch   = 1'b1;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tg;
        ex_pred_taken  = ptk;
        ex_pred_target = ptg;
    endtask

    task automatic idle_ex();
        ex_is_branch   = 1'b0;
        ex_pc          = '0;
        ex_taken       = 1'b0;
        ex_target      = '0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b1; clear_req = 1'b0; idle_ex(); if_pc = 32'h1C000040;
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred: got %b want 0", if_pred_taken); end
        n_vec++; if (if_pred_target !== 32'h1C000044) begin n_err++; $display("FAIL reset_tgt: got %h want 1c000044", if_pred_target); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (stat_branches !== 32'd0) begin n_err++; $display("FAIL reset_br: got %0d want 0", stat_branches); end
        n_vec++; if (stat_mispredicts !== 32'd0) begin n_err++; $display("FAIL reset_mis: got %0d want 0", stat_mispredicts); end
        @(negedge clk); rstn = 1'b1;
        @(negedge clk); #1;
        n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL cold_pred: got %b want 0", if_pred_taken); end
    endtask

    task automatic test_train_hysteresis();
        if_pc = 32'h1C000040;
        @(negedge clk); drive_ex(32'h1C000040, 1'b1, 32'h1C000100, 1'b0, 32'h0); #1;
        n_vec++; if (ex_mispredict !== 1'b1) begin n_err++; $display("FAIL alloc_mis: got %b want 1", ex_mispredict); end
        n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL no_bypass: got %b want 0", if_pred_taken); end
        @(negedge clk); drive_ex(32'h1C000040, 1'b1, 32'h1C000100, 1'b1, 32'h1C000100); #1;
        n_vec++; if (ex_mispredict !== 1'b0) begin n_err++; $display("FAIL correct_mis: got %b want 0", ex_mispredict); end
        n_vec++; if (if_pred_taken !== 1'b1) begin n_err++; $display("FAIL alloc_pred: got %b want 1", if_pred_taken); end
        n_vec++; if (if_pred_target !== 32'h1C000100) begin n_err++; $display("FAIL alloc_tgt: got %h want 1c000100", if_pred_target); end
        n_vec++; if (stat_mispredicts !== 32'd1) begin n_err++; $display("FAIL stat_mis1: got %0d want 1", stat_mispredicts); end
        n_vec++; if (stat_branches !== 32'd1) begin n_err++; $display("FAIL stat_br1: got %0d want 1", stat_branches); end
        @(negedge clk); drive_ex(32'h1C000040, 1'b1, 32'h1C000100, 1'b1, 32'h1C000100); #1;
        n_vec++; if (if_pred_taken !== 1'b1) begin n_err++; $display("FAIL st_pred: got %b want 1", if_pred_taken); end
        // Counter is now saturated at ST; first not-taken must still predict taken
        @(negedge clk); drive_ex(32'h1C000040, 1'b0, 32'h0, 1'b1, 32'h1C000100); #1;
        n_vec++; if (ex_mispredict !== 1'b1) begin n_err++; $display("FAIL nt_mis: got %b want 1", ex_mispredict); end
        n_vec++; if (if_pred_taken !== 1'b1) begin n_err++; $display("FAIL sat_pred: got %b want 1", if_pred_taken); end
        @(negedge clk); drive_ex(32'h1C000040, 1'b0, 32'h0, 1'b1, 32'h1C000100); #1;
        n_vec++; if (if_pred_taken !== 1'b1) begin n_err++; $display("FAIL hyst1_pred: got %b want 1", if_pred_taken); end
        n_vec++; if (if_pred_target !== 32'h1C000100) begin n_err++; $display("FAIL hyst1_tgt: got %h want 1c000100", if_pred_target); end
        @(negedge clk); idle_ex(); #1;
        n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL hyst2_pred: got %b want 0", if_pred_taken); end
        n_vec++; if (if_pred_target !== 32'h1C000044) begin n_err++; $display("FAIL hyst2_tgt: got %h want 1c000044", if_pred_target); end
        n_vec++; if (stat_branches !== 32'd5) begin n_err++; $display("FAIL stat_br5: got %0d want 5", stat_branches); end
        n_vec++; if (stat_mispredicts !== 32'd3) begin n_err++; $display("FAIL stat_mis3: got %0d want 3", stat_mispredicts); end
    endtask

    task automatic test_alias_target();
        @(negedge clk); if_pc = 32'h1C000080;
        drive_ex(32'h1C000080, 1'b1, 32'h1C000200, 1'b1, 32'h1C000100); ex_is_branch = 1'b0; #1;
        n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_pred: got %b want 0", if_pred_taken); end
        n_vec++; if (if_pred_target !== 32'h1C000084) begin n_err++; $display("FAIL alias_tgt: got %h want 1c000084", if_pred_target); end
        n_vec++; if (ex_mispredict !== 1'b0) begin n_err++; $display("FAIL nobranch_mis: got %b want 0", ex_mispredict); end
        ex_is_branch = 1'b1; #1;
        n_vec++; if (ex_mispredict !== 1'b1) begin n_err++; $display("FAIL tgt_mis: got %b want 1", ex_mispredict); end
        @(negedge clk); drive_ex(32'h1C000044, 1'b0, 32'h0, 1'b0, 32'h1C000999); #1;
        n_vec++; if (ex_mispredict !== 1'b0) begin n_err++; $display("FAIL ntnt_mis: got %b want 0", ex_mispredict); end
        n_vec++; if (if_pred_taken !== 1'b1) begin n_err++; $display("FAIL realloc_pred: got %b want 1", if_pred_taken); end
        n_vec++; if (if_pred_target !== 32'h1C000200) begin n_err++; $display("FAIL realloc_tgt: got %h want 1c000200", if_pred_target); end
        @(negedge clk); idle_ex(); if_pc = 32'h1C000040; #1;
        n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL evict_pred: got %b want 0", if_pred_taken); end
        n_vec++; if (stat_branches !== 32'd7) begin n_err++; $display("FAIL stat_br7: got %0d want 7", stat_branches); end
        n_vec++; if (stat_mispredicts !== 32'd4) begin n_err++; $display("FAIL stat_mis4: got %0d want 4", stat_mispredicts); end
        if_pc = 32'h1C000044; #1;
        n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL ntmiss_pred: got %b want 0", if_pred_taken); end
    endtask

    task automatic test_sweep();
        int busy_cycles;
        @(negedge clk); drive_ex(32'h1C00007C, 1'b1, 32'h1C000300, 1'b0, 32'h0);
        @(negedge clk); drive_ex(32'h1C000044, 1'b1, 32'h1C000400, 1'b0, 32'h0);
        clear_req = 1'b1; if_pc = 32'h1C00007C; #1;
        n_vec++; if (ex_mispredict !== 1'b1) begin n_err++; $display("FAIL clr_mis: got %b want 1", ex_mispredict); end
        n_vec++; if (if_pred_target !== 32'h1C000300) begin n_err++; $display("FAIL pre_clr_tgt: got %h want 1c000300", if_pred_target); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL pre_clr_busy: got %b want 0", busy); end
        n_vec++; if (stat_branches !== 32'd8) begin n_err++; $display("FAIL stat_br8: got %0d want 8", stat_branches); end
        @(negedge clk); clear_req = 1'b0;
        drive_ex(32'h1C000048, 1'b1, 32'h1C000500, 1'b0, 32'h0);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!busy) break;
            busy_cycles++;
            n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL sweep_pred[%0d]: got %b want 0", i, if_pred_taken); end
            n_vec++; if (ex_mispredict !== 1'b1) begin n_err++; $display("FAIL sweep_mis[%0d]: got %b want 1", i, ex_mispredict); end
            clear_req = (i == 3);
            @(negedge clk);
        end
        idle_ex(); clear_req = 1'b0;
        n_vec++; if (busy_cycles !== 16) begin n_err++; $display("FAIL busy_len: got %0d want 16", busy_cycles); end
        n_vec++; if (stat_branches !== 32'd0) begin n_err++; $display("FAIL sweep_br: got %0d want 0", stat_branches); end
        n_vec++; if (stat_mispredicts !== 32'd0) begin n_err++; $display("FAIL sweep_mis: got %0d want 0", stat_mispredicts); end
        if_pc = 32'h1C00007C; #1;
        n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL post7c_pred: got %b want 0", if_pred_taken); end
        if_pc = 32'h1C000080; #1;
        n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL post80_pred: got %b want 0", if_pred_taken); end
        if_pc = 32'h1C000044; #1;
        n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL drop44_pred: got %b want 0", if_pred_taken); end
        if_pc = 32'h1C000048; #1;
        n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL drop48_pred: got %b want 0", if_pred_taken); end
        n_vec++; if (if_pred_target !== 32'h1C00004C) begin n_err++; $display("FAIL drop48_tgt: got %h want 1c00004c", if_pred_target); end
    endtask

    task automatic test_reset_mid_sweep();
        @(negedge clk); drive_ex(32'h1C000040, 1'b1, 32'h1C000100, 1'b0, 32'h0);
        @(negedge clk); drive_ex(32'h1C00007C, 1'b1, 32'h1C000300, 1'b0, 32'h0);
        @(negedge clk); idle_ex(); if_pc = 32'h1C00007C; #1;
        n_vec++; if (if_pred_taken !== 1'b1) begin n_err++; $display("FAIL refill_pred: got %b want 1", if_pred_taken); end
        clear_req = 1'b1;
        @(negedge clk); clear_req = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", busy); end
        rstn = 1'b0; #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (if_pred_target !== 32'h1C000080) begin n_err++; $display("FAIL rst_tgt: got %h want 1c000080", if_pred_target); end
        @(negedge clk); rstn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
        n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL empty7c_pred: got %b want 0", if_pred_taken); end
        if_pc = 32'h1C000040; #1;
        n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL empty40_pred: got %b want 0", if_pred_taken); end
        n_vec++; if (stat_branches !== 32'd0) begin n_err++; $display("FAIL rst_br: got %0d want 0", stat_branches); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_train_hysteresis();
        test_alias_target();
        test_sweep();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1);
    end

endmodule
